// File: rtl/sram_req_ctrl.sv
// Request front-end for the 512x32 single-port SRAM macro: registered macro pins and a
// credit-limited read response FIFO. Define SRAM_INIT_EN to enable the post-reset zero-fill sweep.
module sram_req_ctrl #(
    parameter int WORDS  = 512,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(WORDS),
    parameter int DEPTH  = 4
) (
    input  logic                CK,
    input  logic                RSTN,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    input  logic [1:0]          cfg_rddelay,
    input  logic [1:0]          cfg_wrdelay,
    output logic                busy,
    output logic                mem_csn,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    output logic [DATA_W-1:0]   mem_mask,
    output logic [1:0]          mem_rddelay,
    output logic [1:0]          mem_wrdelay,
    input  logic [DATA_W-1:0]   mem_dout
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, RUN} state_e;

    state_e                         state_q, state_d;
    logic                           ready_q, ready_d;
    logic                           csn_q, csn_d, wen_q, wen_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [DATA_W-1:0]              din_q, din_d, mask_q, mask_d;
    logic [1:0]                     rddly_q, wrdly_q;
    logic [1:0]                     rd_pipe_q, rd_pipe_d;
    logic [CNT_W-1:0]               pending_q, pending_d, count_q, count_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][DATA_W-1:0]   fifo_q, fifo_d;
    logic                           rd_acc, push, pop;
`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0]              init_cnt_q, init_cnt_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_ready   = ready_q;
    assign rsp_valid   = (count_q != '0);
    assign rsp_rdata   = fifo_q[rd_ptr_q];
    assign mem_csn     = csn_q;
    assign mem_wen     = wen_q;
    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign mem_mask    = mask_q;
    assign mem_rddelay = rddly_q;
    assign mem_wrdelay = wrdly_q;
    assign busy        = (state_q == INIT);

    always_comb begin
        state_d = state_q;
        csn_d   = 1'b1;
        wen_d   = wen_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mask_d  = mask_q;
        rd_acc  = 1'b0;
`ifdef SRAM_INIT_EN
        init_cnt_d = init_cnt_q;
`endif
        case (state_q)
            INIT: begin
`ifdef SRAM_INIT_EN
                csn_d      = 1'b0;
                wen_d      = 1'b0;
                addr_d     = init_cnt_q;
                din_d      = '0;
                mask_d     = '1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(WORDS - 1)) state_d = RUN;
`else
                state_d = RUN;
`endif
            end
            default: begin
                if (req_valid && ready_q) begin
                    if (!req_we) begin
                        csn_d  = 1'b0;
                        wen_d  = 1'b1;
                        addr_d = req_addr;
                        rd_acc = 1'b1;
                    end else if (|req_be) begin
                        // An all-zero byte-enable write is consumed without touching the macro.
                        csn_d  = 1'b0;
                        wen_d  = 1'b0;
                        addr_d = req_addr;
                        din_d  = req_wdata;
                        for (int i = 0; i < BE_W; i++) mask_d[8*i +: 8] = {8{req_be[i]}};
                    end
                end
            end
        endcase

        // rd_pipe[0]: read on the pins; rd_pipe[1]: macro has sampled it, DOUT valid now.
        rd_pipe_d = {rd_pipe_q[0], rd_acc};
        push      = rd_pipe_q[1];
        pop       = rsp_valid && rsp_ready;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = mem_dout;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        pending_d = pending_q + CNT_W'(rd_acc) - CNT_W'(pop);

        // Registered so that req_ready never depends combinationally on rsp_ready.
        ready_d = (state_d == RUN) && (pending_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
`ifdef SRAM_INIT_EN
            state_q    <= INIT;
            init_cnt_q <= '0;
`else
            state_q    <= RUN;
`endif
            ready_q   <= 1'b0;
            csn_q     <= 1'b1;
            wen_q     <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            mask_q    <= '0;
            rddly_q   <= '0;
            wrdly_q   <= '0;
            rd_pipe_q <= '0;
            pending_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fifo_q    <= '0;
        end else begin
`ifdef SRAM_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
            state_q   <= state_d;
            ready_q   <= ready_d;
            csn_q     <= csn_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            mask_q    <= mask_d;
            rddly_q   <= cfg_rddelay;
            wrdly_q   <= cfg_wrdelay;
            rd_pipe_q <= rd_pipe_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fifo_q    <= fifo_d;
        end
    end
endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request front-end that sits directly upstream of the 512x32 single-port SRAM macro. It converts a valid/ready word-access request stream with byte enables into registered macro pins (CSN, WEN, ADDR, DIN, MASK, RDDELAY, WRDELAY). It captures the macro's DOUT one cycle after each read and buffers it in a response FIFO with valid/ready backpressure. An optional post-reset sweep zero-fills the whole array.

## Interface
- WORDS, 512, macro word count
- DATA_W, 32, data width; must be a multiple of 8
- ADDR_W, $clog2(WORDS), address width
- DEPTH, 4, response FIFO depth and outstanding-read credit limit
- CK  in  1  clock, shared with the macro
- RSTN  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high at posedge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts rsp_rdata
- rsp_rdata  out  DATA_W  read data, head of FIFO
- cfg_rddelay, cfg_wrdelay  in  2 each  macro timing trim values
- busy  out  1  init sweep in progress
- mem_csn, mem_wen  out  1 each  to macro CSN, WEN
- mem_addr  out  ADDR_W  to macro ADDR
- mem_din  out  DATA_W  to macro DIN
- mem_mask  out  DATA_W  to macro MASK; 1 = bit written
- mem_rddelay, mem_wrdelay  out  2 each  to macro RDDELAY, WRDELAY
- mem_dout  in  DATA_W  from macro DOUT

## Operation
- FSM states: INIT, RUN.
  - Reset → INIT when SRAM_INIT_EN is defined, otherwise → RUN.
  - INIT → RUN after the write to address WORDS-1 has been issued.
- req_ready = (state == RUN) && (pending < DEPTH).
  - pending = issued reads not yet popped from the FIFO.
  - req_ready is driven from registers only; there is no combinational path from rsp_ready.
- Accepted read:
  - At the accept edge, register mem_csn=0, mem_wen=1, mem_addr=req_addr.
  - Set pipeline flag rd_pipe.
  - pending += 1.
- Accepted write:
  - At the accept edge, register mem_csn=0, mem_wen=0, mem_addr, mem_din=req_wdata.
  - mem_mask byte i = {8{req_be[i]}}.
  - If req_be is all zero, the write is consumed with no macro access (mem_csn stays 1).
  - Writes produce no response.
- Idle cycle (no accept): mem_csn=1. mem_wen, mem_addr, mem_din and mem_mask hold their last values.
- Capture: at the edge after the macro samples a read (rd_pipe set), push mem_dout into the FIFO.
- Pop: at an edge with rsp_valid && rsp_ready, pop one entry and pending -= 1.
  - Simultaneous push and pop: occupancy is unchanged.
  - Simultaneous accept and pop: pending is unchanged.
- The FIFO cannot overflow because the pending credit covers it. Pop on empty cannot occur because rsp_valid is 0.
- mem_rddelay/mem_wrdelay register cfg_* every cycle.
- Ordering: responses return in read-issue order. A read after a write to the same address returns the new data.

## Timing
- Read latency: accept at edge N → macro samples at N+1 → data captured at N+2 → rsp_valid high in cycle N+2→N+3.
  - Accept-to-rsp_valid is 2 cycles.
- Sustained throughput is 1 read/cycle with rsp_ready held high; pending peaks at 3 < DEPTH.
- Write: the macro commits at edge N+1 after accept at N.
- Reset (RSTN=0 sampled at posedge): all values below take effect at that edge.
  - mem_csn=1, mem_wen=1.
  - mem_addr, mem_din, mem_mask, mem_*delay = 0.
  - rsp_valid=0, rsp_rdata=0, FIFO empty, pending=0, rd_pipe=0.
  - req_ready=0 while RSTN is low.
  - busy=1 if SRAM_INIT_EN, else 0.
- Reset mid-operation: in-flight reads and buffered responses are discarded, and the sweep restarts at address 0.

## Configuration
- SRAM_INIT_EN defined:
  - INIT writes 0 to addresses 0..WORDS-1, one per cycle, with mem_mask all ones.
  - busy=1 and req_ready=0 during the sweep.
  - busy falls and RUN is entered WORDS cycles after reset release.
- SRAM_INIT_EN undefined:
  - No INIT state; busy is tied 0.
  - req_ready is high in the first cycle after reset release.
  - Array contents are unspecified until written.

## Test plan
- Init sweep (SRAM_INIT_EN): release reset → busy high for 512 cycles, mem_csn=0 with mem_wen=0 on addresses 0..511; then read 0x1FF → rsp_rdata=0x00000000.
- Write then read: write 0xDEADBEEF to 0x0A3 with be=4'hF, then read 0x0A3 → rsp_valid 2 cycles after accept, rdata=0xDEADBEEF.
- Byte mask: preload 0x11223344 at 0x010, then write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD. A write with be=0 shows no mem_csn low cycle.
- Back-to-back reads of 0..7 with rsp_ready=1 → req_ready never drops, rsp_valid for 8 consecutive cycles, data in order.
- Backpressure: rsp_ready=0, issue 6 reads → exactly 4 accepted, then req_ready=0. Raise rsp_ready → 4 responses in order, then the remaining 2 are accepted.
- Reset mid-stream: assert RSTN=0 with 2 reads pending → next cycle rsp_valid=0, mem_csn=1, pending=0; no stale response after release.
